input_csr: RTL and testbench
============================

# input_csr

Memory-mapped CSR responder that carries a byte stream into `PolarisCPU`, the receive-side counterpart of `output_csr`. An external producer pushes bytes through a valid/ack handshake into an internal synchronous FIFO. The CPU drains the FIFO by reading a data CSR and monitors or flushes it through a status CSR. The block attaches to the same `cadr`/`coe`/`cwe`/`cvalid`/`cdat` bus as `output_csr`.

## Interface
Parameters:
- `DEPTH_LOG2`, 4, FIFO depth is 2^DEPTH_LOG2 bytes (16).
- `STAT_ADDR`, 12'hFF0, status/control CSR address.
- `DATA_ADDR`, 12'hFF1, receive-data CSR address.
- `COUNT_ADDR`, 12'hFF2, byte-counter CSR address (only with `INPUT_CSR_STATS_EN`).

Ports:
- `clk_i` in 1: single clock, rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `cadr_i` in 12: CSR address from CPU.
- `coe_i` in 1: CSR read strobe, one cycle per CPU read.
- `cwe_i` in 1: CSR write strobe, one cycle per CPU write.
- `cdat_i` in 64: CSR write data.
- `cdat_o` out 64: CSR read data, combinational.
- `cvalid_o` out 1: address decoded by this block, combinational.
- `rx_dat_i` in 8: producer byte.
- `rx_stb_i` in 1: producer byte valid.
- `rx_ack_o` out 1: byte accepted this edge (`rx_stb_i & ~full`).

## Operation
- `cvalid_o` is 1 when `cadr_i` equals `STAT_ADDR` or `DATA_ADDR`, or `COUNT_ADDR` when stats are enabled. It does not depend on `coe_i`/`cwe_i`.
- `cdat_o` is 0 when `cvalid_o` is 0.
- **DATA read:**
  - `cdat_o[63]` = ~empty and `cdat_o[7:0]` = head byte; all other bits are 0.
  - On a clock edge with `coe_i` high, `cadr_i`=DATA_ADDR and FIFO not empty, the head is popped.
  - Reading while empty returns 0 and pops nothing.
- **STAT read:**
  - bit 63 = empty, bit 62 = full.
  - bits [DEPTH_LOG2:0] = occupancy (0..2^DEPTH_LOG2); rest 0.
  - No side effect.
- **STAT write:** on an edge with `cwe_i` high and `cdat_i[0]`=1, the FIFO is flushed (occupancy becomes 0). Other bits are ignored.
- **DATA write:** ignored; `cvalid_o` is still 1.
- **Push:** on an edge with `rx_stb_i & ~full`, the byte enters the tail. `rx_ack_o` is combinational and reflects that acceptance.
- **Full and pop in the same cycle:** no push is accepted (`rx_ack_o`=0). The pop completes.
- **Non-empty, push and pop in the same cycle:** occupancy is unchanged and ordering is preserved.
- **Empty, push and read in the same cycle:** the read returns bit 63=0. The pushed byte is stored and readable next cycle.
- **Flush in the same cycle as push or pop:** flush wins. A byte acked in that cycle is discarded, and occupancy is 0 afterward.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. Occupancy is DEPTH_LOG2+1 bits.

## Timing
- **Reset:** in any cycle with `reset_i` high, FIFO is empty, pointers and counter are 0.
  - `rx_ack_o`=0 while reset is high; `cdat_o` per decode (status shows empty=1).
  - Reset mid-transfer drops all stored bytes.
- **Read latency:** 0 cycles. Data is valid in the same cycle as `coe_i`, and the pop takes effect at that edge.
- A byte pushed at edge N is visible in DATA and STAT from cycle N+1.
- Sustained throughput is one push and one pop per cycle.

## Configuration
- `INPUT_CSR_STATS_EN` defined:
  - Adds a 32-bit count of accepted bytes, readable at `COUNT_ADDR` in `cdat_o[31:0]`.
  - The count wraps at 2^32 and is unaffected by flush.
  - It is cleared by reset or by any write to `COUNT_ADDR`.
- Not defined: the counter logic is absent and `COUNT_ADDR` is not decoded (`cvalid_o`=0 there).

## Structure
- Package `input_csr_pkg` holds:
  - default address constants;
  - status bit positions (`STAT_EMPTY_BIT`=63, `STAT_FULL_BIT`=62, `DATA_VALID_BIT`=63);
  - flush bit index 0.
- Sub-module `csr_fifo`: generic synchronous FIFO (width, depth), with push/pop/flush inputs and head/empty/full/count outputs.
- `input_csr` holds the address decode, read mux, handshake and optional counter.

## Test plan
- **Reset then idle:** STAT read gives 64'h8000_0000_0000_0000; DATA read gives 0; `rx_ack_o`=0 while reset is high.
- **Ordering:** push 8'h41, 8'h42, 8'h43, then three DATA reads give 64'h8000…0041, …0042, …0043. A fourth read gives 0.
- **Fill and backpressure:** 17 consecutive pushes yield 16 acks; the 17th sees `rx_ack_o`=0. STAT reports full=1, count=16. After one pop the held byte is acked next cycle.
- **Simultaneous events:**
  - push and pop with occupancy 3 keeps STAT count at 3;
  - push and read when empty returns 0, then the next read returns the byte.
- **Flush:** fill 5 bytes, write STAT with 64'h1 while pushing 8'h55; afterward STAT shows empty and DATA reads 0.
- **Stats (macro on):** 20 accepted bytes, then a COUNT read gives 20. A flush leaves the count at 20; a write to COUNT_ADDR gives 0. With the macro off, `cvalid_o`=0 at 12'hFF2.

Source files
------------

// File: rtl/input_csr_pkg.sv
// Shared constants and types for the input_csr receive-side CSR block.
// The optional byte counter is enabled with the INPUT_CSR_STATS_EN macro.
package input_csr_pkg;

  localparam logic [11:0] DEF_STAT_ADDR  = 12'hFF0;
  localparam logic [11:0] DEF_DATA_ADDR  = 12'hFF1;
  localparam logic [11:0] DEF_COUNT_ADDR = 12'hFF2;

  localparam int STAT_EMPTY_BIT = 63;
  localparam int STAT_FULL_BIT  = 62;
  localparam int DATA_VALID_BIT = 63;
  localparam int FLUSH_BIT      = 0;
  localparam int COUNT_WIDTH    = 32;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_STAT,
    SEL_DATA,
    SEL_COUNT
  } csr_sel_e;

endpackage

// File: rtl/csr_fifo.sv
// Generic synchronous FIFO with push/pop/flush controls and occupancy output.
// Head data is presented combinationally from the read pointer.
module csr_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [WIDTH-1:0]      o_head,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_doPush;
  logic                  w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == FULL_COUNT);
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;

  // Flush dominates any push/pop issued in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/input_csr.sv
// Receive-side CSR responder: producer bytes enter a FIFO drained via the DATA CSR.
// Define INPUT_CSR_STATS_EN to add the accepted-byte counter at COUNT_ADDR.
module input_csr
  import input_csr_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [11:0] STAT_ADDR  = DEF_STAT_ADDR,
  parameter logic [11:0] DATA_ADDR  = DEF_DATA_ADDR,
  parameter logic [11:0] COUNT_ADDR = DEF_COUNT_ADDR
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [11:0] cadr_i,
  input  logic        coe_i,
  input  logic        cwe_i,
  input  logic [63:0] cdat_i,
  output logic [63:0] cdat_o,
  output logic        cvalid_o,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_stb_i,
  output logic        rx_ack_o
);

`ifdef INPUT_CSR_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  csr_sel_e                     w_sel;
  logic [7:0]                   w_head;
  logic                         w_fifoEmpty;
  logic                         w_fifoFull;
  logic [DEPTH_LOG2:0]          w_fifoCount;
  logic                         w_empty;
  logic                         w_full;
  logic [DEPTH_LOG2:0]          w_occ;
  logic                         w_pop;
  logic                         w_flush;
  logic [COUNT_WIDTH-1:0]       w_countValue;
  logic                         w_unusedWriteBits;

  always_comb begin
    w_sel = SEL_NONE;
    if (cadr_i == STAT_ADDR)                  w_sel = SEL_STAT;
    else if (cadr_i == DATA_ADDR)             w_sel = SEL_DATA;
    else if (STATS_EN && cadr_i == COUNT_ADDR) w_sel = SEL_COUNT;
  end

  // While reset is held the FIFO is presented as empty even before the edge clears it.
  assign w_empty  = w_fifoEmpty | reset_i;
  assign w_full   = w_fifoFull & ~reset_i;
  assign w_occ    = reset_i ? '0 : w_fifoCount;

  assign cvalid_o = (w_sel != SEL_NONE);
  assign rx_ack_o = rx_stb_i & ~w_full & ~reset_i;
  assign w_pop    = coe_i & (w_sel == SEL_DATA) & ~w_empty;
  assign w_flush  = cwe_i & (w_sel == SEL_STAT) & cdat_i[FLUSH_BIT];
  assign w_unusedWriteBits = ^cdat_i[63:1];

  csr_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_push  (rx_ack_o),
    .i_data  (rx_dat_i),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_empty (w_fifoEmpty),
    .o_full  (w_fifoFull),
    .o_count (w_fifoCount)
  );

`ifdef INPUT_CSR_STATS_EN
  logic [COUNT_WIDTH-1:0] r_byteCount;

  // A write to the counter address clears it, even if a byte is accepted that cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i)                          r_byteCount <= '0;
    else if (cwe_i && w_sel == SEL_COUNT) r_byteCount <= '0;
    else if (rx_ack_o)                    r_byteCount <= r_byteCount + 1'b1;
  end

  assign w_countValue = reset_i ? '0 : r_byteCount;
`else
  assign w_countValue = '0;
`endif

  always_comb begin
    cdat_o = '0;
    case (w_sel)
      SEL_STAT: begin
        cdat_o[STAT_EMPTY_BIT] = w_empty;
        cdat_o[STAT_FULL_BIT]  = w_full;
        cdat_o[DEPTH_LOG2:0]   = w_occ;
      end
      SEL_DATA: begin
        cdat_o[DATA_VALID_BIT] = ~w_empty;
        cdat_o[7:0]            = w_empty ? 8'h00 : w_head;
      end
      SEL_COUNT: cdat_o[COUNT_WIDTH-1:0] = w_countValue;
      default:   cdat_o = '0;
    endcase
  end

endmodule

// File: tb/tb_input_csr.sv
// Scoreboard bench for input_csr: a queue-based byte model predicts every cycle's outputs.
// Follows INPUT_CSR_STATS_EN the same way the design does.
module tb_input_csr;
  import input_csr_pkg::*;

`ifdef INPUT_CSR_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif
  localparam int DEPTH = 16;

  typedef struct {
    string       tag;
    logic [63:0] expData;
    bit          expValid;
    bit          expAck;
  } expect_t;

  logic        clock;
  logic        reset;
  logic [11:0] cadr;
  logic        coe;
  logic        cwe;
  logic [63:0] cdatIn;
  logic [63:0] cdatOut;
  logic        cvalid;
  logic [7:0]  rxDat;
  logic        rxStb;
  logic        rxAck;

  expect_t     scoreboard[$];
  expect_t     monItem;
  logic [7:0]  modelQ[$];
  logic [31:0] modelCnt;
  int          testsRun;
  int          failCount;

  input_csr dut (
    .clk_i    (clock),
    .reset_i  (reset),
    .cadr_i   (cadr),
    .coe_i    (coe),
    .cwe_i    (cwe),
    .cdat_i   (cdatIn),
    .cdat_o   (cdatOut),
    .cvalid_o (cvalid),
    .rx_dat_i (rxDat),
    .rx_stb_i (rxStb),
    .rx_ack_o (rxAck)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one cycle of inputs, predict that cycle's outputs, then advance the model past the edge.
  task automatic applyStimulus(input logic [11:0] addr, input bit oe, input bit we,
                               input logic [63:0] wdat, input bit stb, input logic [7:0] dat,
                               input bit rst, input string tag);
    expect_t     e;
    logic [63:0] expData;
    logic [4:0]  occ;
    bit          empty, full, valid, ack, flush, pop;
    cadr = addr; coe = oe; cwe = we; cdatIn = wdat;
    rxStb = stb; rxDat = dat; reset = rst;

    occ   = rst ? 5'd0 : 5'(modelQ.size());
    empty = (occ == 0);
    full  = (occ == DEPTH);
    valid = (addr == DEF_STAT_ADDR) || (addr == DEF_DATA_ADDR) ||
            (STATS_EN && addr == DEF_COUNT_ADDR);
    ack   = stb && !full && !rst;
    expData = '0;
    if (addr == DEF_STAT_ADDR) begin
      expData[63]  = empty;
      expData[62]  = full;
      expData[4:0] = occ;
    end else if (addr == DEF_DATA_ADDR) begin
      if (!empty) expData = {1'b1, 55'd0, modelQ[0]};
    end else if (STATS_EN && addr == DEF_COUNT_ADDR) begin
      expData[31:0] = rst ? 32'd0 : modelCnt;
    end
    e.tag = tag; e.expData = expData; e.expValid = valid; e.expAck = ack;
    scoreboard.push_back(e);

    if (rst) begin
      modelQ.delete();
      modelCnt = '0;
    end else begin
      flush = we && addr == DEF_STAT_ADDR && wdat[0];
      pop   = oe && addr == DEF_DATA_ADDR && !empty;
      if (flush) modelQ.delete();
      else begin
        if (pop) void'(modelQ.pop_front());
        if (ack) modelQ.push_back(dat);
      end
      if (STATS_EN && we && addr == DEF_COUNT_ADDR) modelCnt = '0;
      else if (ack) modelCnt = modelCnt + 32'd1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input expect_t e);
    testsRun++;
    if (cvalid !== e.expValid) begin
      failCount++;
      $display("[TB] FAIL %s cvalid: got %0b expected %0b", e.tag, cvalid, e.expValid);
    end
    testsRun++;
    if (cdatOut !== e.expData) begin
      failCount++;
      $display("[TB] FAIL %s cdat: got %h expected %h", e.tag, cdatOut, e.expData);
    end
    testsRun++;
    if (rxAck !== e.expAck) begin
      failCount++;
      $display("[TB] FAIL %s rx_ack: got %0b expected %0b", e.tag, rxAck, e.expAck);
    end
  endtask

  always @(negedge clock) begin
    if (scoreboard.size() > 0) begin
      monItem = scoreboard.pop_front();
      checkOutput(monItem);
    end
  end

  task automatic pushByte(input logic [7:0] b, input string tag);
    applyStimulus(12'h000, 1'b0, 1'b0, 64'd0, 1'b1, b, 1'b0, tag);
  endtask

  task automatic readAddr(input logic [11:0] a, input bit stb, input logic [7:0] b, input string tag);
    applyStimulus(a, 1'b1, 1'b0, 64'd0, stb, b, 1'b0, tag);
  endtask

  initial begin
    testsRun = 0; failCount = 0; modelCnt = '0;
    cadr = '0; coe = 0; cwe = 0; cdatIn = '0; rxStb = 0; rxDat = '0; reset = 1;
    @(posedge clock);
    #1;

    // Reset with the producer strobing: no acks, status shows empty.
    applyStimulus(DEF_STAT_ADDR, 1, 0, 64'd0, 1, 8'hAA, 1, "reset_stat");
    applyStimulus(DEF_DATA_ADDR, 1, 0, 64'd0, 1, 8'hAA, 1, "reset_data");
    readAddr(DEF_STAT_ADDR, 0, 8'h00, "idle_stat");
    readAddr(DEF_DATA_ADDR, 0, 8'h00, "idle_data");

    pushByte(8'h41, "order_push");
    pushByte(8'h42, "order_push");
    pushByte(8'h43, "order_push");
    repeat (4) readAddr(DEF_DATA_ADDR, 0, 8'h00, "order_read");

    for (int i = 0; i < 17; i++) pushByte(8'(8'h60 + i), "fill_push");
    readAddr(DEF_STAT_ADDR, 1, 8'h71, "full_stat");
    readAddr(DEF_DATA_ADDR, 1, 8'h71, "full_pop");
    pushByte(8'h71, "held_push");
    for (int i = 0; i < 17; i++) readAddr(DEF_DATA_ADDR, 0, 8'h00, "drain");

    for (int i = 0; i < 3; i++) pushByte(8'(8'h30 + i), "occ3_push");
    readAddr(DEF_DATA_ADDR, 1, 8'h33, "push_pop");
    readAddr(DEF_STAT_ADDR, 0, 8'h00, "occ3_stat");
    for (int i = 0; i < 3; i++) readAddr(DEF_DATA_ADDR, 0, 8'h00, "drain");
    readAddr(DEF_DATA_ADDR, 1, 8'h99, "empty_push_read");
    readAddr(DEF_DATA_ADDR, 0, 8'h00, "empty_next_read");

    for (int i = 0; i < 5; i++) pushByte(8'(8'h10 + i), "flush_fill");
    applyStimulus(DEF_STAT_ADDR, 0, 1, 64'h1, 1, 8'h55, 0, "flush_push");
    readAddr(DEF_STAT_ADDR, 0, 8'h00, "flush_stat");
    readAddr(DEF_DATA_ADDR, 0, 8'h00, "flush_data");

    // Mid-transfer reset drops stored bytes.
    pushByte(8'hC1, "pre_reset_push");
    pushByte(8'hC2, "pre_reset_push");
    applyStimulus(DEF_STAT_ADDR, 1, 0, 64'd0, 1, 8'hC3, 1, "midreset_stat");
    readAddr(DEF_DATA_ADDR, 0, 8'h00, "post_reset_data");

    pushByte(8'h00, "stats_push");
    for (int i = 1; i < 20; i++) readAddr(DEF_DATA_ADDR, 1, 8'(i), "stats_push_pop");
    readAddr(DEF_COUNT_ADDR, 0, 8'h00, "count20");
    applyStimulus(DEF_STAT_ADDR, 0, 1, 64'h1, 0, 8'h00, 0, "stats_flush");
    readAddr(DEF_COUNT_ADDR, 0, 8'h00, "count_after_flush");
    applyStimulus(DEF_COUNT_ADDR, 0, 1, 64'h0, 0, 8'h00, 0, "count_clear");
    readAddr(DEF_COUNT_ADDR, 0, 8'h00, "count_cleared");

    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      logic [63:0] w;
      case ($urandom_range(0, 4))
        0:       a = DEF_STAT_ADDR;
        1, 2:    a = DEF_DATA_ADDR;
        3:       a = DEF_COUNT_ADDR;
        default: a = 12'($urandom);
      endcase
      w = {32'($urandom), 32'($urandom)};
      applyStimulus(a, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, w,
                    $urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 199) == 0, "random");
    end

    applyStimulus(12'h000, 0, 0, 64'd0, 0, 8'h00, 0, "final_idle");
    repeat (3) @(posedge clock);
    testsRun++;
    if (scoreboard.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", scoreboard.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
